uart_frm_rx: RTL and testbench
==============================

UART_FRM_RX -- requirements
Module: uart_frm_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clk cycles per UART bit period (minimum 4).
REQ-002 Parameter TMO_BITS, default 16, inter-byte timeout in bit periods; used only under REQ-030.
REQ-003 clk  input  1  system clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 RX  input  1  asynchronous UART serial input, idle high, 8N1, LSB first.
REQ-006 clr_rdy  input  1  consumer acknowledge, clears frm_rdy.
REQ-007 cfg_data  output  24  last complete 3-byte frame, first received byte in [23:16].
REQ-008 frm_rdy  output  1  high while an unacknowledged frame is held in cfg_data.
REQ-009 ovr_err  output  1  one-cycle pulse when a complete frame is dropped.

Function
REQ-010 RX SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; all later references to RX mean the synchronized value.
REQ-011 Bit FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE: RX==0 -> START, baud counter loaded with BAUD_DIV/2 (integer division).
REQ-013 START: at counter expiry, RX==0 -> DATA with counter reloaded to BAUD_DIV; RX==1 -> IDLE (false start, no byte).
REQ-014 DATA: sample RX at each counter expiry into shift register (LSB first); after 8th sample -> STOP.
REQ-015 STOP: at counter expiry, RX==1 -> byte accepted, IDLE; RX==0 -> framing error, byte discarded, byte counter cleared to 0, IDLE.
REQ-016 Byte counter (0..2) SHALL advance on each accepted byte; bytes 0 and 1 latched into internal holding registers.
REQ-017 On acceptance of byte 2: if frm_rdy==0 or clr_rdy==1 that cycle, cfg_data <= {byte0, byte1, byte2} and frm_rdy <= 1 on the same edge; otherwise frame dropped, cfg_data unchanged, ovr_err pulsed for that one cycle.
REQ-018 Byte counter SHALL wrap to 0 after byte 2 regardless of accept or drop.
REQ-019 clr_rdy with no simultaneous frame completion SHALL clear frm_rdy on the next edge; clr_rdy while frm_rdy==0 has no effect.
REQ-020 Simultaneous clr_rdy and frame completion: set wins, frm_rdy stays 1, cfg_data takes the new frame.
REQ-021 cfg_data SHALL change only per REQ-017; it is stable for the whole time frm_rdy==1.
REQ-022 Latency: frm_rdy rises on the edge that samples the stop bit of byte 2, measured after the 2-cycle synchronizer.
REQ-023 RX held low indefinitely (break) SHALL yield a framing error once, then remain in IDLE until RX returns high and falls again.

Reset
REQ-024 rst_n low SHALL immediately set: FSM IDLE, byte counter 0, baud counter 0, shift and holding registers 0, cfg_data 24'h000000, frm_rdy 0, ovr_err 0, synchronizer flops 1.
REQ-025 Reset mid-byte or mid-frame SHALL discard all partial data; the first frame after reset starts at byte 0.

Configuration
REQ-030 Macro FRM_TMO_EN defined: idle counter runs while byte counter != 0 and FSM in IDLE; reaching TMO_BITS*BAUD_DIV cycles clears byte counter to 0 (partial frame discarded, no ovr_err); counter clears on every start bit.
REQ-031 FRM_TMO_EN undefined: no idle counter; a partial frame is held indefinitely until completed, a framing error, or reset.

Verification (BAUD_DIV=8, TMO_BITS=4)
REQ-040 Send bytes 0xC1, 0x23, 0x45 -> cfg_data==24'hC12345, frm_rdy rises on byte-2 stop-bit sample edge, ovr_err stays 0.
REQ-041 Frame 0x0C 0x00 0x10, no clr_rdy, then frame 0x11 0x22 0x33 -> cfg_data remains 24'h0C0010, one-cycle ovr_err pulse; pulse clr_rdy -> frm_rdy 0 next edge.
REQ-042 Assert clr_rdy on exactly the byte-2 completion edge of frame 0xAA 0xBB 0xCC while frm_rdy==1 -> frm_rdy stays 1, cfg_data==24'hAABBCC.
REQ-043 RX low glitch of 2 cycles, then byte with stop bit 0 followed by 0x01 0x02 0x03 -> no false byte, framing error clears counter, cfg_data==24'h010203.
REQ-044 Send 0x12, idle 40 cycles, send 0x34 0x56 0x78: with FRM_TMO_EN -> frame incomplete (0x34,0x56,0x78 form bytes 0..2, cfg_data==24'h345678); without -> cfg_data==24'h123456.
REQ-045 Assert rst_n low during DATA of byte 1 -> all outputs reset values, next full frame 0x01 0x02 0x03 yields 24'h010203.

Source files
------------

// File: rtl/uart_frm_rx.sv
// UART 8N1 receiver that packs three accepted bytes into a 24-bit config frame.
// Optional inter-byte timeout is enabled with `define FRM_TMO_EN.
module uart_frm_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int TMO_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_rdy,
  output logic [23:0] cfg_data,
  output logic        frm_rdy,
  output logic        ovr_err,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

  if (BAUD_DIV < 4 || TMO_BITS < 1) begin : g_bad_param
    $error("uart_frm_rx: BAUD_DIV must be >= 4 and TMO_BITS >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_nxt;
  logic           rx_s1, rx_s2, rx_prev;
  logic           rx_fall;
  logic [CW-1:0]  baud_cnt;
  logic           expire;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic [1:0]     byte_cnt;
  logic [7:0]     hold0, hold1;
  logic           load_half, load_full, shift_en, byte_ok, frm_err;
  logic           frm_done;
  logic           tmo_hit;

  // rx_prev is one more stage so a start needs a genuine high-to-low edge;
  // this keeps a held-low line (break) from retriggering after its framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall   = rx_prev & ~rx_s2;
  assign expire    = (baud_cnt == CW'(1));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    frm_err   = 1'b0;
    case (state)
      IDLE: if (rx_fall) begin
        state_nxt = START;
        load_half = 1'b1;
      end
      START: if (expire) begin
        if (!rx_s2) begin
          state_nxt = DATA;
          load_full = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: if (expire) begin
        shift_en  = 1'b1;
        load_full = 1'b1;
        if (bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (expire) begin
        state_nxt = IDLE;
        byte_ok   = rx_s2;
        frm_err   = ~rx_s2;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      if (load_half)                            baud_cnt <= HALF;
      else if (load_full)                       baud_cnt <= FULL;
      else if (state != IDLE && baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
      if (shift_en) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

`ifdef FRM_TMO_EN
  localparam int TMO_CYC = TMO_BITS * BAUD_DIV;
  localparam int TW      = $clog2(TMO_CYC + 1);
  logic [TW-1:0] idle_cnt;

  assign tmo_hit = (state == IDLE) && (byte_cnt != 2'd0) && (idle_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           idle_cnt <= '0;
    else if (state != IDLE || byte_cnt == 2'd0 || tmo_hit) idle_cnt <= '0;
    else                                                  idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign frm_done = byte_ok && (byte_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      hold0    <= 8'h00;
      hold1    <= 8'h00;
    end else if (frm_err || tmo_hit) begin
      byte_cnt <= 2'd0;
    end else if (byte_ok) begin
      case (byte_cnt)
        2'd0:    begin hold0 <= shreg; byte_cnt <= 2'd1; end
        2'd1:    begin hold1 <= shreg; byte_cnt <= 2'd2; end
        default: byte_cnt <= 2'd0;
      endcase
    end
  end

  // A completing frame beats a simultaneous clr_rdy; cfg_data only moves on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_data <= 24'h000000;
      frm_rdy  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (frm_done) begin
        if (!frm_rdy || clr_rdy) begin
          cfg_data <= {hold0, hold1, shreg};
          frm_rdy  <= 1'b1;
        end else begin
          ovr_err <= 1'b1;
        end
      end else if (clr_rdy) begin
        frm_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frm_rx.sv
// Bench for uart_frm_rx (BAUD_DIV=8, TMO_BITS=4): directed scenarios plus random frames
// checked against a byte/frame-level model; honours FRM_TMO_EN when defined.
module tb_uart_frm_rx;

  localparam int BD = 8;
  localparam int TB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        clr_rdy = 1'b0;
  logic [23:0] cfg_data;
  logic        frm_rdy;
  logic        ovr_err;
  logic [1:0]  dbg_state;

  int nvec = 0;
  int nerr = 0;

  // Model: bytes of the frame in progress, plus the expected output holding state.
  logic [7:0]  exp_q[$];
  logic        m_rdy = 1'b0;
  logic [23:0] m_cfg = 24'h000000;

  uart_frm_rx #(.BAUD_DIV(BD), .TMO_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .clr_rdy(clr_rdy),
    .cfg_data(cfg_data), .frm_rdy(frm_rdy), .ovr_err(ovr_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BD) tick();
  endtask

  // Stop bit is sampled by the DUT 7 edges into it (sync latency + half-bit start);
  // outputs are checked on both sides of that edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic clr_at_stop);
    logic exp_ovr;
    logic done;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rx = stop_ok;
    repeat (BD - 2) tick();
    chk("pre_rdy", frm_rdy, m_rdy);
    chk("pre_cfg", cfg_data, m_cfg);
    clr_rdy = clr_at_stop;
    tick();
    clr_rdy = 1'b0;
    exp_ovr = 1'b0;
    done    = 1'b0;
    if (!stop_ok) begin
      exp_q.delete();
    end else begin
      exp_q.push_back(b);
      if (exp_q.size() == 3) begin
        done = 1'b1;
        if (!m_rdy || clr_at_stop) begin
          m_cfg = {exp_q[0], exp_q[1], exp_q[2]};
          m_rdy = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
        exp_q.delete();
      end
    end
    if (!done && clr_at_stop) m_rdy = 1'b0;
    chk("stop_rdy", frm_rdy, m_rdy);
    chk("stop_cfg", cfg_data, m_cfg);
    chk("stop_ovr", ovr_err, exp_ovr);
    tick();
    chk("ovr_pulse_end", ovr_err, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic clr_last);
    send_byte(b0, 1'b1, 1'b0);
    send_byte(b1, 1'b1, 1'b0);
    send_byte(b2, 1'b1, clr_last);
  endtask

  // Idle span seen by the DUT is n plus about 4 cycles (stop tail + sync + edge detect).
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
`ifdef FRM_TMO_EN
    if (n + 4 >= TB * BD) exp_q.delete();
`endif
  endtask

  task automatic clr_pulse();
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
    m_rdy = 1'b0;
    chk("clr_rdy", frm_rdy, m_rdy);
    chk("clr_cfg", cfg_data, m_cfg);
  endtask

  initial begin
    logic [7:0] b;
    logic       bad;
    logic       clr_last;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cfg", cfg_data, 24'h000000);
    chk("reset_rdy", frm_rdy, 1'b0);
    chk("reset_ovr", ovr_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();

    // basic frame
    send_frame(8'hC1, 8'h23, 8'h45, 1'b0);
    chk("f040_cfg", cfg_data, 24'hC12345);
    chk("f040_rdy", frm_rdy, 1'b1);
    clr_pulse();

    // overrun drop, then set-beats-clear on completion
    send_frame(8'h0C, 8'h00, 8'h10, 1'b0);
    send_frame(8'h11, 8'h22, 8'h33, 1'b0);
    chk("f041_cfg_held", cfg_data, 24'h0C0010);
    send_frame(8'hAA, 8'hBB, 8'hCC, 1'b1);
    chk("f042_cfg", cfg_data, 24'hAABBCC);
    chk("f042_rdy", frm_rdy, 1'b1);
    clr_pulse();
    chk("f041_rdy_cleared", frm_rdy, 1'b0);

    // short glitch, framing error mid-frame, then a clean frame
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (12) tick();
    chk("glitch_rdy", frm_rdy, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h99, 1'b0, 1'b0);
    idle(16);
    send_frame(8'h01, 8'h02, 8'h03, 1'b0);
    chk("f043_cfg", cfg_data, 24'h010203);
    clr_pulse();

    // break: line held low long after a partial frame
    send_byte(8'h77, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (300) tick();
    exp_q.delete();
    chk("break_ovr", ovr_err, 1'b0);
    idle(20);
    send_frame(8'h04, 8'h05, 8'h06, 1'b0);
    chk("break_cfg", cfg_data, 24'h040506);
    clr_pulse();

    // long gap inside a frame
    send_byte(8'h12, 1'b1, 1'b0);
    idle(40);
    send_byte(8'h34, 1'b1, 1'b0);
    send_byte(8'h56, 1'b1, 1'b0);
    send_byte(8'h78, 1'b1, 1'b0);
`ifdef FRM_TMO_EN
    chk("f044_cfg", cfg_data, 24'h345678);
`else
    chk("f044_cfg", cfg_data, 24'h123456);
`endif
    chk("f044_rdy", frm_rdy, 1'b1);

    // random traffic: bytes, occasional framing errors, clears and short gaps
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 3; k++) begin
        b        = 8'($urandom_range(0, 255));
        bad      = ($urandom_range(0, 9) == 0);
        clr_last = (k == 2) && ($urandom_range(0, 1) == 1);
        send_byte(b, !bad, clr_last);
        if (bad) idle(12);
        else     idle($urandom_range(0, 6));
      end
      if ($urandom_range(0, 3) == 0) clr_pulse();
    end

    // reset in the middle of byte 1
    send_frame(8'h31, 8'h32, 8'h33, 1'b1);
    chk("pre_reset_rdy", frm_rdy, 1'b1);
    send_byte(8'h9A, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (BD) tick();
    rx = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_cfg", cfg_data, 24'h000000);
    chk("midrst_rdy", frm_rdy, 1'b0);
    chk("midrst_ovr", ovr_err, 1'b0);
    exp_q.delete();
    m_rdy = 1'b0;
    m_cfg = 24'h000000;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h01, 8'h02, 8'h03, 1'b0);
    chk("f045_cfg", cfg_data, 24'h010203);
    chk("f045_rdy", frm_rdy, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
